// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, ALU_Op values,
// mux selects and the decoded control word.
package multicycle_control_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_EXEC_LUI = 4'd4;
  localparam logic [3:0] S_MEM_ADDR = 4'd5;
  localparam logic [3:0] S_MEM_RD   = 4'd6;
  localparam logic [3:0] S_MEM_WR   = 4'd7;
  localparam logic [3:0] S_WB_ALU   = 4'd8;
  localparam logic [3:0] S_WB_MEM   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    ALU_R    = 3'b000,
    ALU_I    = 3'b001,
    ALU_LUI  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_RSVD = 3'b100
  } alu_op_t;

  localparam logic [1:0] SRC_A_PC   = 2'b00;
  localparam logic [1:0] SRC_A_RS1  = 2'b01;
  localparam logic [1:0] SRC_A_ZERO = 2'b10;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LUI, CLS_LOAD, CLS_STORE, CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       result_src;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic op_class_t classify(input logic [6:0] op);
    case (op)
      OP_R:     return CLS_R;
      OP_I:     return CLS_I;
      OP_LUI:   return CLS_LUI;
      OP_LOAD:  return CLS_LOAD;
      OP_STORE: return CLS_STORE;
      default:  return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_control_if;
  logic [6:0] opcode_i;
  logic       mem_ready_i;
  logic       pc_write_o;
  logic       ir_write_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       reg_write_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [2:0] alu_op_o;
  logic       result_src_o;
  logic       instr_done_o;
  logic       illegal_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, instr_done_o, illegal_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o, instr_done_o, illegal_o
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational state-to-control decoder; mem_ack only qualifies the handshake-completion
// strobes (IR/PC load in FETCH, retire in MEM_WR), everything else depends on state alone.
module multicycle_control_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ack,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ack;
        ctrl.pc_write  = mem_ack;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_R;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_I;
      end
      S_EXEC_LUI: begin
        ctrl.alu_src_a = SRC_A_ZERO;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_LUI;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: ctrl.mem_read = 1'b1;
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ack;
      end
      S_WB_ALU: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_TRAP: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU controller FSM: fetch/decode/execute/memory/write-back sequencing,
// memory waits stretch FETCH, MEM_RD and MEM_WR until mem_ready_i.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_if.master       bus
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  op_class_t  cls_q;
  ctrl_t      ctrl;
  logic       mem_ack;

  // A handshake seen while reset is held must not produce a write-enable pulse.
  assign mem_ack = bus.mem_ready_i & ~reset;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (classify(bus.opcode_i))
          CLS_R:     state_d = S_EXEC_R;
          CLS_I:     state_d = S_EXEC_I;
          CLS_LUI:   state_d = S_EXEC_LUI;
          CLS_LOAD,
          CLS_STORE: state_d = S_MEM_ADDR;
          default:   state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (cls_q == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = bus.mem_ready_i ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_d = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
      S_WB_ALU, S_WB_MEM: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        cls_q <= classify(bus.opcode_i);
    end
  end

  multicycle_control_decode u_decode (
    .state   (state_q),
    .mem_ack (mem_ack),
    .ctrl    (ctrl)
  );

  assign bus.pc_write_o   = ctrl.pc_write;
  assign bus.ir_write_o   = ctrl.ir_write;
  assign bus.mem_read_o   = ctrl.mem_read;
  assign bus.mem_write_o  = ctrl.mem_write;
  assign bus.reg_write_o  = ctrl.reg_write;
  assign bus.alu_src_a_o  = ctrl.alu_src_a;
  assign bus.alu_src_b_o  = ctrl.alu_src_b;
  assign bus.alu_op_o     = ctrl.alu_op;
  assign bus.result_src_o = ctrl.result_src;
  assign bus.instr_done_o = ctrl.instr_done;
  assign bus.illegal_o    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: reset checks, a latency/ALU_Op vector table, directed
// corner sequences and random instruction traces against a cycle-by-cycle expected trace.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] T_ADD  = 7'b0110011;
  localparam logic [6:0] T_ADDI = 7'b0010011;
  localparam logic [6:0] T_LUI  = 7'b0110111;
  localparam logic [6:0] T_LW   = 7'b0000011;
  localparam logic [6:0] T_SW   = 7'b0100011;
  localparam logic [6:0] T_BAD  = 7'b1111111;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic       result_src;
    logic       instr_done;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       ready;
    logic [6:0] op;
    outs_t      exp;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    int         lat;
    logic [2:0] op3;
    int         regw;
  } vec_t;

  cyc_t trace[$];
  int   checks = 0;
  int   failures = 0;

  function automatic outs_t got();
    outs_t o;
    o.mem_read   = bus.mem_read_o;
    o.mem_write  = bus.mem_write_o;
    o.pc_write   = bus.pc_write_o;
    o.ir_write   = bus.ir_write_o;
    o.reg_write  = bus.reg_write_o;
    o.src_a      = bus.alu_src_a_o;
    o.src_b      = bus.alu_src_b_o;
    o.alu_op     = bus.alu_op_o;
    o.result_src = bus.result_src_o;
    o.instr_done = bus.instr_done_o;
    o.illegal    = bus.illegal_o;
    return o;
  endfunction

  function automatic outs_t alu_cyc(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
    outs_t o = '0;
    o.src_a  = a;
    o.src_b  = b;
    o.alu_op = op;
    return o;
  endfunction

  function automatic outs_t fetch_cyc(input logic done);
    outs_t o = alu_cyc(2'b00, 2'b10, 3'b011);
    o.mem_read = 1'b1;
    o.pc_write = done;
    o.ir_write = done;
    return o;
  endfunction

  function automatic outs_t wb_cyc(input logic from_mem);
    outs_t o = '0;
    o.reg_write  = 1'b1;
    o.instr_done = 1'b1;
    o.result_src = from_mem;
    return o;
  endfunction

  function automatic logic [6:0] pick(input int later);
    if (later < 0) return 7'($urandom);
    return later[6:0];
  endfunction

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, g, e);
    end
  endtask

  task automatic push(input logic rdy, input logic [6:0] op, input outs_t e);
    cyc_t c;
    c.ready = rdy;
    c.op    = op;
    c.exp   = e;
    trace.push_back(c);
  endtask

  // Expected per-cycle trace of one instruction; `later` forces opcode_i after DECODE.
  task automatic build(input logic [6:0] op, input int wf, input int wm, input int later);
    outs_t e;
    trace.delete();
    for (int i = 0; i < wf; i++) push(1'b0, pick(-1), fetch_cyc(1'b0));
    push(1'b1, pick(-1), fetch_cyc(1'b1));
    push(1'($urandom), op, '0);
    case (op)
      T_ADD:  begin push(1'($urandom), pick(later), alu_cyc(2'b01, 2'b00, 3'b000)); push(1'($urandom), pick(later), wb_cyc(1'b0)); end
      T_ADDI: begin push(1'($urandom), pick(later), alu_cyc(2'b01, 2'b01, 3'b001)); push(1'($urandom), pick(later), wb_cyc(1'b0)); end
      T_LUI:  begin push(1'($urandom), pick(later), alu_cyc(2'b10, 2'b01, 3'b010)); push(1'($urandom), pick(later), wb_cyc(1'b0)); end
      T_LW: begin
        push(1'($urandom), pick(later), alu_cyc(2'b01, 2'b01, 3'b011));
        e = '0; e.mem_read = 1'b1;
        for (int i = 0; i < wm; i++) push(1'b0, pick(later), e);
        push(1'b1, pick(later), e);
        push(1'($urandom), pick(later), wb_cyc(1'b1));
      end
      default: begin
        push(1'($urandom), pick(later), alu_cyc(2'b01, 2'b01, 3'b011));
        e = '0; e.mem_write = 1'b1;
        for (int i = 0; i < wm; i++) push(1'b0, pick(later), e);
        e.instr_done = 1'b1;
        push(1'b1, pick(later), e);
      end
    endcase
  endtask

  // Plays the first n trace cycles (all if n < 0); returns the cycle number of the first retire.
  task automatic run(input string name, input int n, output int done_at);
    outs_t g;
    int    lim;
    done_at = 0;
    lim = (n < 0) ? trace.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk);
      #1;
      bus.mem_ready_i = trace[i].ready;
      bus.opcode_i    = trace[i].op;
      @(negedge clk);
      g = got();
      check($sformatf("%s_cyc%0d", name, i + 1), 32'(g), 32'(trace[i].exp));
      if (g.instr_done && done_at == 0) done_at = i + 1;
    end
  endtask

  initial begin
    vec_t       tab[5];
    logic [6:0] ops[5];
    int         base[5];
    int         d;
    outs_t      trap_o;

    tab[0] = '{T_ADD,  4, 3'b000, 1};
    tab[1] = '{T_ADDI, 4, 3'b001, 1};
    tab[2] = '{T_LUI,  4, 3'b010, 1};
    tab[3] = '{T_LW,   5, 3'b011, 1};
    tab[4] = '{T_SW,   4, 3'b011, 0};
    ops  = '{T_ADD, T_ADDI, T_LUI, T_LW, T_SW};
    base = '{4, 4, 4, 5, 4};

    // Reset: FETCH decode with every write enable low even while memory reports ready.
    reset = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.opcode_i = T_ADDI;
    #2;
    check("reset_async", 32'(got()), 32'(fetch_cyc(1'b0)));
    @(negedge clk);
    check("reset_held", 32'(got()), 32'(fetch_cyc(1'b0)));
    bus.mem_ready_i = 1'b0;
    reset = 1'b0;

    foreach (tab[k]) begin
      int lat, regw;
      logic [2:0] op3;
      lat = 0; regw = 0; op3 = 3'b111;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk);
        #1;
        bus.mem_ready_i = 1'b1;
        bus.opcode_i = tab[k].op;
        @(negedge clk);
        if (c == 3) op3 = bus.alu_op_o;
        regw += int'(bus.reg_write_o);
        if (bus.instr_done_o) begin
          lat = c;
          break;
        end
      end
      check($sformatf("tab%0d_latency", k), lat, tab[k].lat);
      check($sformatf("tab%0d_aluop3", k), 32'(op3), 32'(tab[k].op3));
      check($sformatf("tab%0d_regwrites", k), regw, tab[k].regw);
    end

    build(T_ADDI, 0, 0, -1); run("addi", -1, d); check("addi_done", d, 4);
    build(T_LW, 0, 3, -1);   run("lw_wait3", -1, d); check("lw_wait3_done", d, 8);
    build(T_SW, 1, 2, -1);   run("sw_wait", -1, d); check("sw_wait_done", d, 7);
    build(T_LW, 0, 0, int'(T_SW)); run("lw_to_sw", -1, d); check("lw_to_sw_done", d, 5);

    // Async reset in the middle of a load's memory wait.
    build(T_LW, 0, 5, -1);
    run("lw_abort", 5, d);
    #2 reset = 1'b1;
    #1 check("abort_async_fetch", 32'(got()), 32'(fetch_cyc(1'b0)));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_held%0d", i), 32'(got()), 32'(fetch_cyc(1'b0)));
    end
    reset = 1'b0;

    // Illegal opcode: TRAP is absorbing for 10 cycles, then reset clears it.
    trace.delete();
    push(1'b1, pick(-1), fetch_cyc(1'b1));
    push(1'b0, T_BAD, '0);
    trap_o = '0;
    trap_o.illegal = 1'b1;
    for (int i = 0; i < 10; i++) push(1'($urandom), pick(-1), trap_o);
    run("trap", -1, d);
    #2 reset = 1'b1;
    #1 check("trap_reset_fetch", 32'(got()), 32'(fetch_cyc(1'b0)));
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    reset = 1'b0;

    for (int r = 0; r < 25; r++) begin
      int sel, wf, wm;
      sel = $urandom_range(0, 4);
      wf  = $urandom_range(0, 2);
      wm  = (sel >= 3) ? $urandom_range(0, 3) : 0;
      build(ops[sel], wf, wm, -1);
      run($sformatf("rnd%0d", r), -1, d);
      check($sformatf("rnd%0d_latency", r), d, base[sel] + wf + wm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
